// File: rtl/melody_seq.sv
// melody_seq: plays one of four constant melodies on request.
// Each melody is a list of up to eight {frequency, duration} entries; a zero
// duration marks the end of the list. Durations are counted in ticks of
// TICK_MS milliseconds derived from CLK_HZ.
// Optional feature macro: MELODY_TONE_OUT_EN adds a square-wave speaker
// drive on tone_out; without it tone_out is tied low.
module melody_seq #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_MS = 50,
   parameter int unsigned FREQ_W  = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        sel,
   input  logic              abort,
   output logic [FREQ_W-1:0] freq,
   output logic              busy,
   output logic              done,
   output logic [2:0]        note_idx,
   output logic              tone_out
);

   // A zero-length tick would stall the sequencer forever, so clamp to one cycle.
   localparam int unsigned TICK_RAW    = CLK_HZ / 1000 * TICK_MS;
   localparam int unsigned TICK_CYCLES = (TICK_RAW == 0) ? 1 : TICK_RAW;
   localparam logic [31:0] TICK_LAST   = 32'(TICK_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PLAY   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   // Constant melody table, packed as {freq_hz[15:0], dur_ticks[7:0]}.
   function automatic logic [23:0] melody_entry(input logic [1:0] m, input logic [2:0] i);
      logic [23:0] e;
      e = 24'd0;
      case (m)
         2'd0: begin
            case (i)
               3'd0:    e = {16'd330, 8'd3};
               3'd1:    e = {16'd392, 8'd3};
               3'd2:    e = {16'd659, 8'd3};
               3'd3:    e = {16'd523, 8'd3};
               3'd4:    e = {16'd587, 8'd3};
               3'd5:    e = {16'd784, 8'd3};
               default: e = 24'd0;
            endcase
         end
         2'd1: begin
            case (i)
               3'd0:    e = {16'd622, 8'd6};
               3'd1:    e = {16'd587, 8'd6};
               3'd2:    e = {16'd554, 8'd6};
               default: e = 24'd0;
            endcase
         end
         2'd2: begin
            case (i)
               3'd0:    e = {16'd523, 8'd2};
               3'd1:    e = {16'd0,   8'd1};
               3'd2:    e = {16'd523, 8'd2};
               default: e = 24'd0;
            endcase
         end
         default: begin
            case (i)
               3'd0:    e = {16'd200, 8'd4};
               default: e = 24'd0;
            endcase
         end
      endcase
      return e;
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        mel_q, mel_d;
   logic [2:0]        idx_q, idx_d;
   logic [31:0]       presc_q, presc_d;
   logic [7:0]        tick_q, tick_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [2:0]        note_idx_q, note_idx_d;

   logic [23:0] cur_entry;
   logic [23:0] next_entry;
   logic [23:0] first_entry;
   logic [2:0]  next_idx;

   assign next_idx    = idx_q + 3'd1;
   assign cur_entry   = melody_entry(mel_q, idx_q);
   assign next_entry  = melody_entry(mel_q, next_idx);
   assign first_entry = melody_entry(sel, 3'd0);

   // Next-state and next-output logic for the sequencer; abort has priority over note advance.
   always_comb begin
      state_d    = state_q;
      mel_d      = mel_q;
      idx_d      = idx_q;
      presc_d    = presc_q;
      tick_d     = tick_q;
      freq_d     = freq_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      note_idx_d = note_idx_q;
      case (state_q)
         S_IDLE: begin
            freq_d     = '0;
            busy_d     = 1'b0;
            note_idx_d = 3'd0;
            idx_d      = 3'd0;
            presc_d    = 32'd0;
            tick_d     = 8'd0;
            if (start && !abort) begin
               state_d = S_PLAY;
               mel_d   = sel;
               freq_d  = FREQ_W'(first_entry[23:8]);
               busy_d  = 1'b1;
            end
         end
         S_PLAY: begin
            if (abort) begin
               state_d    = S_IDLE;
               freq_d     = '0;
               busy_d     = 1'b0;
               note_idx_d = 3'd0;
               idx_d      = 3'd0;
               presc_d    = 32'd0;
               tick_d     = 8'd0;
            end else if (presc_q == TICK_LAST) begin
               presc_d = 32'd0;
               if (tick_q == cur_entry[7:0] - 8'd1) begin
                  tick_d = 8'd0;
                  if (idx_q == 3'd7 || next_entry[7:0] == 8'd0) begin
                     state_d    = S_FINISH;
                     freq_d     = '0;
                     busy_d     = 1'b0;
                     done_d     = 1'b1;
                     note_idx_d = 3'd0;
                     idx_d      = 3'd0;
                  end else begin
                     idx_d      = next_idx;
                     note_idx_d = next_idx;
                     freq_d     = FREQ_W'(next_entry[23:8]);
                  end
               end else begin
                  tick_d = tick_q + 8'd1;
               end
            end else begin
               presc_d = presc_q + 32'd1;
            end
         end
         S_FINISH: begin
            state_d    = S_IDLE;
            freq_d     = '0;
            busy_d     = 1'b0;
            note_idx_d = 3'd0;
            idx_d      = 3'd0;
            presc_d    = 32'd0;
            tick_d     = 8'd0;
         end
         default: begin
            state_d    = S_IDLE;
            freq_d     = '0;
            busy_d     = 1'b0;
            note_idx_d = 3'd0;
            idx_d      = 3'd0;
            presc_d    = 32'd0;
            tick_d     = 8'd0;
         end
      endcase
   end

   // Sequencer state and registered outputs, cleared asynchronously on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         mel_q      <= 2'd0;
         idx_q      <= 3'd0;
         presc_q    <= 32'd0;
         tick_q     <= 8'd0;
         freq_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         note_idx_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         mel_q      <= mel_d;
         idx_q      <= idx_d;
         presc_q    <= presc_d;
         tick_q     <= tick_d;
         freq_q     <= freq_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         note_idx_q <= note_idx_d;
      end
   end

   assign freq     = freq_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign note_idx = note_idx_q;

`ifdef MELODY_TONE_OUT_EN
   // Half period in clock cycles for a given tone, never less than one cycle.
   function automatic logic [31:0] half_calc(input logic [15:0] f);
      logic [31:0] h;
      if (f == 16'd0) begin
         h = 32'd1;
      end else begin
         h = CLK_HZ / (32'd2 * 32'(f));
         if (h == 32'd0) h = 32'd1;
      end
      return h;
   endfunction

   logic [31:0] half_tab [32];

   for (genvar g = 0; g < 32; g++) begin : g_half
      localparam logic [23:0] ENT  = melody_entry(2'(g / 8), 3'(g % 8));
      localparam logic [31:0] HALF = half_calc(ENT[23:8]);
      assign half_tab[g] = HALF;
   end

   logic [31:0] phase_q, phase_d;
   logic        tone_q, tone_d;
   logic        note_load;
   logic [31:0] cur_half;

   assign note_load = (state_d == S_PLAY) && ((state_q != S_PLAY) || (idx_d != idx_q));
   assign cur_half  = half_tab[{mel_q, idx_q}];

   // Phase counter restarts on every note load and stays cleared while silent.
   always_comb begin
      phase_d = phase_q;
      tone_d  = tone_q;
      if (note_load || freq_d == '0) begin
         phase_d = 32'd0;
         tone_d  = 1'b0;
      end else if (phase_q == cur_half - 32'd1) begin
         phase_d = 32'd0;
         tone_d  = ~tone_q;
      end else begin
         phase_d = phase_q + 32'd1;
      end
   end

   // Square-wave generator registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= 32'd0;
         tone_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         tone_q  <= tone_d;
      end
   end

   assign tone_out = tone_q;
`else
   assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_melody_seq.sv
// tb_melody_seq: scoreboard bench for melody_seq at CLK_HZ=10000, TICK_MS=1.
// Stimulus pushes the expected output-change events of each melody into a
// queue; a monitor pops one event every time the DUT outputs change.
module tb_melody_seq;

   localparam int TICK = 10;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [1:0]  sel;
   logic        abort;
   logic [31:0] freq;
   logic        busy;
   logic        done;
   logic [2:0]  note_idx;
   logic        tone_out;

   melody_seq #(
      .CLK_HZ (10_000),
      .TICK_MS(1),
      .FREQ_W (32)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .sel     (sel),
      .abort   (abort),
      .freq    (freq),
      .busy    (busy),
      .done    (done),
      .note_idx(note_idx),
      .tone_out(tone_out)
   );

   typedef struct {
      int f;
      int b;
      int d;
      int idx;
      int at;
   } ev_t;

   ev_t sb[$];
   int  total = 0;
   int  bad   = 0;
   int  cyc   = 0;
   int  mel_f [4][8];
   int  mel_d [4][8];

   int  prev_f = 0;
   int  prev_b = 0;
   int  prev_d = 0;
   int  prev_i = 0;
   int  exp_f  = 0;
   int  tphase = 0;
   int  thalf  = 1;
   int  ttone  = 0;

   // Free-running clock and edge counter
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic int melodyLen(input int m);
      int t;
      t = 0;
      for (int i = 0; i < 8; i++) begin
         if (mel_d[m][i] == 0) break;
         t += mel_d[m][i] * TICK;
      end
      return t;
   endfunction

   // Reference: list of output-change events for melody m started at edge s
   function automatic void pushExpected(input int m, input int s, input int abort_off);
      ev_t list[$];
      ev_t e;
      int  t;
      t = s;
      for (int i = 0; i < 8; i++) begin
         if (mel_d[m][i] == 0) break;
         e = '{mel_f[m][i], 1, 0, i, t};
         list.push_back(e);
         t += mel_d[m][i] * TICK;
      end
      e = '{0, 0, 1, 0, t};
      list.push_back(e);
      e = '{0, 0, 0, 0, t + 1};
      list.push_back(e);
      if (abort_off > 0) begin
         while (list.size() > 0 && list[list.size()-1].at >= s + abort_off)
            void'(list.pop_back());
         e = '{0, 0, 0, 0, s + abort_off};
         list.push_back(e);
      end
      foreach (list[k]) sb.push_back(list[k]);
   endfunction

   // Monitor: on every output change pop and compare one expected event
   always begin
      ev_t e;
      bit  loaded;
      @(posedge clk);
      #1;
      loaded = 1'b0;
      if (reset_n) begin
         if (int'(freq) != prev_f || int'(busy) != prev_b ||
             int'(done) != prev_d || int'(note_idx) != prev_i) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_change: got freq=%0d busy=%0d done=%0d idx=%0d expected no change (cycle %0d)",
                        freq, busy, done, note_idx, cyc);
            end else begin
               e = sb.pop_front();
               checkOutput("event_cycle", cyc, e.at);
               checkOutput("freq", int'(freq), e.f);
               checkOutput("busy", int'(busy), e.b);
               checkOutput("done", int'(done), e.d);
               checkOutput("note_idx", int'(note_idx), e.idx);
               exp_f  = e.f;
               loaded = (e.b == 1);
            end
            prev_f = int'(freq);
            prev_b = int'(busy);
            prev_d = int'(done);
            prev_i = int'(note_idx);
         end
`ifdef MELODY_TONE_OUT_EN
         if (loaded && exp_f != 0) begin
            tphase = 0;
            ttone  = 0;
            thalf  = 10_000 / (2 * exp_f);
            if (thalf < 1) thalf = 1;
         end else if (exp_f == 0) begin
            tphase = 0;
            ttone  = 0;
         end else begin
            tphase++;
            if (tphase == thalf) begin
               ttone  = 1 - ttone;
               tphase = 0;
            end
         end
`else
         ttone = 0;
`endif
         checkOutput("tone_out", int'(tone_out), ttone);
      end
   end

   task automatic waitDrain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_pending", sb.size(), 0);
      sb.delete();
      repeat (2) @(negedge clk);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_done", int'(done), 0);
   endtask

   // One melody request with optional ignored restart and abort (offsets in edges after start)
   task automatic applyStimulus(input int m, input int abort_off, input int spur_off);
      int s;
      int len;
      len = melodyLen(m);
      @(negedge clk);
      s     = cyc + 1;
      start = 1'b1;
      sel   = 2'(m);
      abort = 1'b0;
      pushExpected(m, s, abort_off);
      for (int k = 1; k <= len + 2; k++) begin
         @(negedge clk);
         start = (k == spur_off);
         abort = (k == abort_off);
         sel   = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      waitDrain();
   endtask

   // Stimulus sequence
   initial begin
      mel_f = '{'{330, 392, 659, 523, 587, 784, 0, 0},
                '{622, 587, 554, 0, 0, 0, 0, 0},
                '{523, 0, 523, 0, 0, 0, 0, 0},
                '{200, 0, 0, 0, 0, 0, 0, 0}};
      mel_d = '{'{3, 3, 3, 3, 3, 3, 0, 0},
                '{6, 6, 6, 0, 0, 0, 0, 0},
                '{2, 1, 2, 0, 0, 0, 0, 0},
                '{4, 0, 0, 0, 0, 0, 0, 0}};
      reset_n = 1'b0;
      start   = 1'b0;
      sel     = 2'd0;
      abort   = 1'b0;
      #2;
      checkOutput("reset_freq", int'(freq), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_note_idx", int'(note_idx), 0);
      checkOutput("reset_tone", int'(tone_out), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      applyStimulus(0, 0, 0);
      applyStimulus(2, 0, 0);
      applyStimulus(1, 70, 40);
      applyStimulus(3, 0, 0);
      applyStimulus(0, 180, 0);

      // start and abort in the same cycle from idle: abort wins
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      sel   = 2'd1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checkOutput("start_abort_busy", int'(busy), 0);
      checkOutput("start_abort_freq", int'(freq), 0);
      waitDrain();

      // reset in the middle of melody 0: outputs clear immediately, no done pulse
      @(negedge clk);
      start = 1'b1;
      sel   = 2'd0;
      pushExpected(0, cyc + 1, 0);
      @(negedge clk);
      start = 1'b0;
      repeat (50) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_freq", int'(freq), 0);
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_done", int'(done), 0);
      checkOutput("midreset_note_idx", int'(note_idx), 0);
      checkOutput("midreset_tone", int'(tone_out), 0);
      sb.delete();
      prev_f = 0;
      prev_b = 0;
      prev_d = 0;
      prev_i = 0;
      exp_f  = 0;
      tphase = 0;
      ttone  = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      waitDrain();

      // randomized requests
      for (int r = 0; r < 10; r++) begin
         int m;
         int len;
         int a;
         int sp;
         m   = int'($urandom_range(0, 3));
         len = melodyLen(m);
         a   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : 0;
         sp  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, len - 1)) : 0;
         if (a != 0 && sp >= a) sp = 0;
         applyStimulus(m, a, sp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/melody_seq.md
MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter TICK_MS, default 50, duration unit in ms; TICK_CYCLES = CLK_HZ/1000*TICK_MS.
REQ-003 Parameter FREQ_W, default 32, width of freq output.
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request to play melody sel.
REQ-007 sel  in  2  melody select: 0 win, 1 lose, 2 ready, 3 error.
REQ-008 abort  in  1  stop playback immediately.
REQ-009 freq  out  FREQ_W  current note frequency in Hz, 0 = silence.
REQ-010 busy  out  1  high while a melody plays.
REQ-011 done  out  1  one-cycle pulse on normal melody completion.
REQ-012 note_idx  out  3  index of the note now playing.
REQ-013 tone_out  out  1  square-wave speaker drive.

Function
REQ-014 Melody table SHALL be constant, max 8 entries each, entry = {freq Hz, dur ticks}; dur 0 = end marker.
REQ-015 Melody 0 SHALL be 330,392,659,523,587,784 Hz, 3 ticks each; melody 1 622,587,554 Hz, 6 ticks each.
REQ-016 Melody 2 SHALL be 523 Hz 2 ticks, 0 Hz (rest) 1 tick, 523 Hz 2 ticks; melody 3 200 Hz 4 ticks.
REQ-017 FSM states SHALL be IDLE, PLAY, FINISH; illegal encodings SHALL go to IDLE.
REQ-018 IDLE: start=1 and abort=0 latches sel, loads entry 0, clears tick prescaler, goes PLAY; busy=1 and freq=entry 0 on next cycle.
REQ-019 PLAY: each entry SHALL hold exactly dur*TICK_CYCLES cycles, then load next entry with no gap cycle.
REQ-020 PLAY: after last entry (next dur=0 or index 7) SHALL go FINISH.
REQ-021 FINISH: lasts one cycle with busy=0, freq=0, done=1, note_idx=0; then IDLE.
REQ-022 start while busy SHALL be ignored; sel changes while busy SHALL be ignored.
REQ-023 abort=1 in PLAY SHALL go IDLE next cycle: busy=0, freq=0, done stays 0.
REQ-024 abort and start same cycle in IDLE: abort wins, no playback.
REQ-025 freq, busy, done, note_idx SHALL be registered outputs.
REQ-026 Rest entries (freq 0) SHALL keep busy=1 and count duration normally.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, freq=0, busy=0, done=0, note_idx=0, tone_out=0, all counters 0.
REQ-028 Reset mid-melody SHALL abandon playback with no done pulse; release resumes in IDLE.

Configuration
REQ-029 Macro MELODY_TONE_OUT_EN defined: tone_out toggles every HALF = max(1, CLK_HZ/(2*freq)) cycles, HALF computed per table entry at elaboration.
REQ-030 With MELODY_TONE_OUT_EN: tone_out=0 and phase counter cleared whenever freq=0 and on every note change, first toggle HALF cycles after load.
REQ-031 Without MELODY_TONE_OUT_EN: tone_out tied 0, no phase counter logic; all other behaviour identical.

Verification (CLK_HZ=10_000, TICK_MS=1, TICK_CYCLES=10)
REQ-032 start, sel=0 -> freq 330 next cycle, changes every 30 cycles through 784, busy high exactly 180 cycles, done pulse 1 cycle as busy falls.
REQ-033 start, sel=2 -> freq 523 for 20 cycles, 0 for 10 cycles with busy=1, 523 for 20, then done; note_idx 0,1,2.
REQ-034 start sel=1, abort at cycle 70 -> busy=0, freq=0 next cycle, no done; second start at cycle 40 ignored, freq still 622.
REQ-035 start and abort same cycle -> busy stays 0; reset_n low mid sel=0 -> all outputs 0 immediately, no done.
REQ-036 MELODY_TONE_OUT_EN, sel=3 -> tone_out toggles every 25 cycles for 40 cycles, then 0; undefined -> tone_out constant 0.
